// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage array with true-LRU replacement.
// Provides combinational lookup, fill/write-hit, and a flush engine that
// walks every line and streams dirty lines over a valid/ready port.
module dcache_sram_nway #(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int TAG_W  = 23,
    parameter int LINE_W = 256,
    localparam int WAY_W = $clog2(WAYS),
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [TAG_W+1:0]  tag_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              hit_o,
    output logic [TAG_W+1:0]  tag_o,
    output logic [LINE_W-1:0] data_o,
    output logic [WAY_W-1:0]  way_o,
    input  logic              flush_i,
    input  logic              flush_inval_i,
    output logic              flush_busy_o,
    output logic              flush_done_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [IDX_W-1:0]  wb_idx_o,
    output logic [TAG_W-1:0]  wb_tag_o,
    output logic [LINE_W-1:0] wb_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WB,
        ST_DONE
    } state_t;

    // Line storage; data/tag are cleared on reset, so these are flops rather than RAM
    logic              valid_reg [SETS][WAYS];
    logic              dirty_reg [SETS][WAYS];
    logic [TAG_W-1:0]  tag_reg   [SETS][WAYS];
    logic [LINE_W-1:0] data_reg  [SETS][WAYS];
    logic [WAY_W-1:0]  age_reg   [SETS][WAYS];

    state_t                   state_reg;
    logic [IDX_W+WAY_W-1:0]   ptr_reg;
    logic                     inval_reg;

    logic [WAYS-1:0]  hit_vec;
    logic [WAYS-1:0]  inv_vec;
    logic [WAYS-1:0]  lru_vec;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] lru_way;
    logic [WAY_W-1:0] sel_way;

    logic [IDX_W-1:0] ptr_set;
    logic [WAY_W-1:0] ptr_way;
    logic             last_line;
    logic             scan_dirty;
    logic             scan_step;
    logic             wb_fire;
    logic             clr_valid;
    logic             clr_dirty;
    logic             access_en;
    logic             do_write;
    logic             do_touch;

    // The stored valid bit is always forced on a write, so the incoming one is unused
    logic unused_tag_valid;
    assign unused_tag_valid = tag_i[TAG_W+1];

    // Per-way match, empty and least-recently-used flags for the addressed set
    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way_flags
            assign hit_vec[gi] = valid_reg[addr_i][gi] &&
                                 (tag_reg[addr_i][gi] == tag_i[TAG_W-1:0]);
            assign inv_vec[gi] = ~valid_reg[addr_i][gi];
            assign lru_vec[gi] = (age_reg[addr_i][gi] == WAY_W'(WAYS-1));
        end
    endgenerate

    // Way selection: lowest hit, else lowest empty, else the oldest way
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        lru_way = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (inv_vec[w]) inv_way = WAY_W'(w);
            if (lru_vec[w]) lru_way = WAY_W'(w);
        end
        if (|hit_vec)      sel_way = hit_way;
        else if (|inv_vec) sel_way = inv_way;
        else               sel_way = lru_way;
    end

    assign way_o  = sel_way;
    assign hit_o  = (|hit_vec) & ~flush_busy_o;
    assign tag_o  = {valid_reg[addr_i][sel_way], dirty_reg[addr_i][sel_way],
                     tag_reg[addr_i][sel_way]};
    assign data_o = data_reg[addr_i][sel_way];

    // Accesses are locked out for the whole flush so the walk sees a frozen array
    assign access_en = enable_i & ~flush_busy_o;
    assign do_write  = access_en & write_i;
    assign do_touch  = do_write | (access_en & (|hit_vec));

    assign ptr_set    = ptr_reg[IDX_W+WAY_W-1:WAY_W];
    assign ptr_way    = ptr_reg[WAY_W-1:0];
    assign last_line  = &ptr_reg;
    assign scan_dirty = valid_reg[ptr_set][ptr_way] & dirty_reg[ptr_set][ptr_way];
    assign scan_step  = (state_reg == ST_SCAN) & ~scan_dirty;
    assign wb_fire    = (state_reg == ST_WB) & wb_valid_o & wb_ready_i;
    assign clr_valid  = inval_reg & (scan_step | wb_fire);
    assign clr_dirty  = wb_fire;

    // Array update: fills/write-hits, LRU aging, and flush-driven bit clears
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_reg[s][w] <= 1'b0;
                    dirty_reg[s][w] <= 1'b0;
                    tag_reg[s][w]   <= '0;
                    data_reg[s][w]  <= '0;
                    age_reg[s][w]   <= WAY_W'(w);
                end
            end
        end else begin
            if (do_write) begin
                valid_reg[addr_i][sel_way] <= 1'b1;
                dirty_reg[addr_i][sel_way] <= tag_i[TAG_W];
                tag_reg[addr_i][sel_way]   <= tag_i[TAG_W-1:0];
                data_reg[addr_i][sel_way]  <= data_i;
            end
            if (do_touch) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age_reg[addr_i][w] < age_reg[addr_i][sel_way])
                        age_reg[addr_i][w] <= age_reg[addr_i][w] + 1'b1;
                end
                age_reg[addr_i][sel_way] <= '0;
            end
            if (clr_valid) valid_reg[ptr_set][ptr_way] <= 1'b0;
            if (clr_dirty) dirty_reg[ptr_set][ptr_way] <= 1'b0;
        end
    end

    // Flush engine: set-major walk, parks in WB until the consumer takes the line
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            inval_reg    <= 1'b0;
            flush_busy_o <= 1'b0;
            flush_done_o <= 1'b0;
            wb_valid_o   <= 1'b0;
            wb_idx_o     <= '0;
            wb_tag_o     <= '0;
            wb_data_o    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (flush_i) begin
                        state_reg    <= ST_SCAN;
                        ptr_reg      <= '0;
                        inval_reg    <= flush_inval_i;
                        flush_busy_o <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (scan_dirty) begin
                        state_reg  <= ST_WB;
                        wb_valid_o <= 1'b1;
                        wb_idx_o   <= ptr_set;
                        wb_tag_o   <= tag_reg[ptr_set][ptr_way];
                        wb_data_o  <= data_reg[ptr_set][ptr_way];
                    end else if (last_line) begin
                        state_reg    <= ST_DONE;
                        flush_done_o <= 1'b1;
                    end else begin
                        ptr_reg <= ptr_reg + 1'b1;
                    end
                end
                ST_WB: begin
                    if (wb_ready_i) begin
                        wb_valid_o <= 1'b0;
                        if (last_line) begin
                            state_reg    <= ST_DONE;
                            flush_done_o <= 1'b1;
                        end else begin
                            state_reg <= ST_SCAN;
                            ptr_reg   <= ptr_reg + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    flush_done_o <= 1'b0;
                    flush_busy_o <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
